// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and width constants for the external bus responder
package bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2
    } state_t;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W = 4;
    localparam int WAIT_W = 8;
    localparam logic [BE_W-1:0] BE_N_IDLE = 4'hF;
endpackage

// File: rtl/bus_cycle_responder_if.sv
// bus_cycle_responder_if: internal request/ready bus plus external pin group
interface bus_cycle_responder_if;
    import bus_pkg::*;
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_write_enable;
    logic [ADDR_W-1:0] i_req_address;
    logic [BE_W-1:0]   i_req_byte_enable;
    logic [DATA_W-1:0] i_req_data_write;
    logic [DATA_W-1:0] o_req_data_read;
    logic              o_req_error;
    logic              o_ads_n;
    logic              o_w_r_n;
    logic              o_m_io_n;
    logic              o_d_c_n;
    logic [ADDR_W-3:0] o_address;
    logic [BE_W-1:0]   o_byte_enable_n;
    logic [DATA_W-1:0] o_data_out;
    logic              o_data_oe;
    logic [DATA_W-1:0] i_data_in;
    logic              i_ready_n;

    modport slave (
        input  i_req_valid, i_req_write_enable, i_req_address, i_req_byte_enable,
               i_req_data_write, i_data_in, i_ready_n,
        output o_req_ready, o_req_data_read, o_req_error, o_ads_n, o_w_r_n, o_m_io_n,
               o_d_c_n, o_address, o_byte_enable_n, o_data_out, o_data_oe
    );
    modport master (
        output i_req_valid, i_req_write_enable, i_req_address, i_req_byte_enable,
               i_req_data_write, i_data_in, i_ready_n,
        input  o_req_ready, o_req_data_read, o_req_error, o_ads_n, o_w_r_n, o_m_io_n,
               o_d_c_n, o_address, o_byte_enable_n, o_data_out, o_data_oe
    );
endinterface

// File: rtl/bus_wait_counter.sv
// bus_wait_counter: T2 wait-state counter; terminal flags the last allowed high sample
module bus_wait_counter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    logic [WAIT_W-1:0] count;

    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + 1'b1;

    assign terminal = count == WAIT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/bus_cycle_responder.sv
// bus_cycle_responder: runs one non-pipelined T1/T2 external bus cycle per internal request
module bus_cycle_responder
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clock,
    input logic reset,
    bus_cycle_responder_if.slave bus
);
    state_t state;
    logic wait_done;
    logic unused_addr_bits;

    assign unused_addr_bits = ^bus.i_req_address[1:0];
    assign bus.o_m_io_n = 1'b1;
    assign bus.o_d_c_n = 1'b1;

    bus_wait_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait (
        .clock(clock),
        .reset(reset),
        .clear(state == T1),
        .enable(state == T2 && bus.i_ready_n),
        .terminal(wait_done)
    );

    // The pin registers double as the request latches for the duration of the cycle
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            bus.o_req_ready <= 1'b0;
            bus.o_req_error <= 1'b0;
            bus.o_req_data_read <= '0;
            bus.o_ads_n <= 1'b1;
            bus.o_w_r_n <= 1'b0;
            bus.o_address <= '0;
            bus.o_byte_enable_n <= BE_N_IDLE;
            bus.o_data_out <= '0;
            bus.o_data_oe <= 1'b0;
        end else begin
            bus.o_req_ready <= 1'b0;
            case (state)
                IDLE: if (bus.i_req_valid) begin
                    if (bus.i_req_byte_enable == '0) begin
                        bus.o_req_ready <= 1'b1;
                        bus.o_req_error <= 1'b0;
                        bus.o_req_data_read <= '0;
                    end else begin
                        state <= T1;
                        bus.o_ads_n <= 1'b0;
                        bus.o_w_r_n <= bus.i_req_write_enable;
                        bus.o_address <= bus.i_req_address[ADDR_W-1:2];
                        bus.o_byte_enable_n <= ~bus.i_req_byte_enable;
                        bus.o_data_oe <= bus.i_req_write_enable;
                        if (bus.i_req_write_enable) bus.o_data_out <= bus.i_req_data_write;
                    end
                end
                T1: begin
                    bus.o_ads_n <= 1'b1;
                    state <= T2;
                end
                T2: if (!bus.i_ready_n || wait_done) begin
                    state <= IDLE;
                    bus.o_req_ready <= 1'b1;
                    bus.o_req_error <= bus.i_ready_n;
                    bus.o_req_data_read <= (bus.i_ready_n || bus.o_w_r_n) ? '0 : bus.i_data_in;
                    bus.o_byte_enable_n <= BE_N_IDLE;
                    bus.o_data_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_bus_cycle_responder.sv
// tb_bus_cycle_responder: randomized transactions checked cycle-by-cycle against a timeline model
module tb_bus_cycle_responder;
    localparam int TO = 4;

    typedef struct {
        logic        rst_chk;
        logic        ready;
        logic        err;
        logic [31:0] rdata;
        logic        ads_n;
        logic        bus_chk;
        logic        wr;
        logic [29:0] addr;
        logic [3:0]  be_n;
        logic        oe;
        logic [31:0] dout;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bus_cycle_responder_if bus();
    bus_cycle_responder #(.TIMEOUT_CYCLES(TO)) dut (.clock(clock), .reset(reset), .bus(bus));

    rec_t q[$];
    int total = 0;
    int bad = 0;
    logic [29:0] last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        rec_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready", 32'(bus.o_req_ready), 32'(e.ready));
            chk("ads_n", 32'(bus.o_ads_n), 32'(e.ads_n));
            chk("be_n", 32'(bus.o_byte_enable_n), 32'(e.be_n));
            chk("data_oe", 32'(bus.o_data_oe), 32'(e.oe));
            chk("address", 32'(bus.o_address), 32'(e.addr));
            chk("m_io_n", 32'(bus.o_m_io_n), 32'd1);
            chk("d_c_n", 32'(bus.o_d_c_n), 32'd1);
            if (e.ready || e.rst_chk) begin
                chk("error", 32'(bus.o_req_error), 32'(e.err));
                chk("data_read", bus.o_req_data_read, e.rdata);
            end
            if (e.bus_chk || e.rst_chk) chk("w_r_n", 32'(bus.o_w_r_n), 32'(e.wr));
            if ((e.bus_chk && e.oe) || e.rst_chk) chk("data_out", bus.o_data_out, e.dout);
        end
    end

    function automatic rec_t idle();
        rec_t r;
        r = '{default: '0};
        r.ads_n = 1'b1;
        r.be_n = 4'hF;
        r.addr = last_addr;
        return r;
    endfunction

    task automatic push(input rec_t r);
        q.push_back(r);
        @(negedge clock);
    endtask

    task automatic gap();
        bus.i_req_valid = 1'b0;
        push(idle());
    endtask

    task automatic junk();
        bus.i_req_valid = 1'($urandom);
        bus.i_req_write_enable = 1'($urandom);
        bus.i_req_address = $urandom;
        bus.i_req_byte_enable = 4'($urandom);
        bus.i_req_data_write = $urandom;
    endtask

    task automatic reset_cycle();
        rec_t r;
        last_addr = '0;
        r = idle();
        r.rst_chk = 1'b1;
        push(r);
    endtask

    // lat = cycles from the valid-sampling edge to the ready pulse; -1 if aborted by reset
    task automatic txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int nwait, input logic [31:0] rd,
                       input int abort, output int lat);
        rec_t r, b;
        bus.i_req_valid = 1'b1;
        bus.i_req_write_enable = we;
        bus.i_req_address = a;
        bus.i_req_byte_enable = be;
        bus.i_req_data_write = wd;
        bus.i_ready_n = 1'($urandom);
        bus.i_data_in = $urandom;
        lat = 1;
        if (be == 4'h0) begin
            r = idle();
            r.ready = 1'b1;
            push(r);
            bus.i_req_valid = 1'b0;
            return;
        end
        last_addr = a[31:2];
        b = idle();
        b.ads_n = 1'b0;
        b.bus_chk = 1'b1;
        b.wr = we;
        b.addr = a[31:2];
        b.be_n = ~be;
        b.oe = we;
        b.dout = wd;
        push(b);
        junk();
        bus.i_ready_n = 1'($urandom);
        b.ads_n = 1'b1;
        lat++;
        push(b);
        for (int i = 0; ; i++) begin
            junk();
            if (i == abort) begin
                bus.i_req_valid = 1'b0;
                reset = 1'b1;
                reset_cycle();
                reset = 1'b0;
                lat = -1;
                return;
            end
            bus.i_ready_n = (i < nwait);
            bus.i_data_in = (i == nwait) ? rd : $urandom;
            lat++;
            if (i == nwait || i + 1 == TO) begin
                r = idle();
                r.ready = 1'b1;
                r.err = (i != nwait);
                r.rdata = (i != nwait || we) ? 32'h0 : rd;
                push(r);
                break;
            end
            push(b);
        end
        bus.i_req_valid = 1'b0;
    endtask

    initial begin
        int lat, lat2, ab;
        logic [3:0] be;
        bus.i_req_valid = 1'b0;
        bus.i_req_write_enable = 1'b0;
        bus.i_req_address = '0;
        bus.i_req_byte_enable = '0;
        bus.i_req_data_write = '0;
        bus.i_data_in = '0;
        bus.i_ready_n = 1'b1;
        reset_cycle();
        reset_cycle();
        reset = 1'b0;
        gap();

        txn(1'b0, 32'h0000_1004, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, -1, lat);
        chk("lat_read", 32'(lat), 32'd3);
        chk("model_addr", 32'(last_addr), 32'h401);
        gap();
        txn(1'b1, 32'h8000_0000, 4'b0011, 32'h1234_5678, 2, 32'h0, -1, lat);
        chk("lat_write_2w", 32'(lat), 32'd5);
        gap();
        txn(1'b0, 32'h0000_2000, 4'hF, 32'h0, 100, 32'h5555_AAAA, -1, lat);
        chk("lat_timeout", 32'(lat), 32'd6);
        gap();
        txn(1'b1, 32'h0000_3000, 4'h0, 32'hFFFF_FFFF, 0, 32'h0, -1, lat);
        chk("lat_zero_be", 32'(lat), 32'd1);
        gap();
        txn(1'b1, 32'h0000_4008, 4'hC, 32'hCAFE_F00D, 5, 32'h0, 1, lat);
        chk("lat_abort", 32'(lat), -32'sd1);
        txn(1'b0, 32'h0000_500C, 4'h1, 32'h0, 0, 32'h0BAD_CAFE, -1, lat);
        chk("lat_after_reset", 32'(lat), 32'd3);
        txn(1'b0, 32'h0000_6000, 4'hF, 32'h0, 0, 32'h1111_2222, -1, lat);
        txn(1'b1, 32'h0000_6004, 4'hF, 32'h3333_4444, 0, 32'h0, -1, lat2);
        chk("lat_b2b_first", 32'(lat), 32'd3);
        chk("lat_b2b_second", 32'(lat2), 32'd3);
        gap();

        for (int n = 0; n < 80; n++) begin
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1;
            txn(1'($urandom), $urandom, be, $urandom, int'($urandom_range(0, 6)), $urandom, ab, lat);
            repeat ($urandom_range(0, 2)) gap();
        end
        gap();
        gap();
        @(posedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
